burst_detector: RTL and testbench
=================================

Name: burst_detector

Overview:
- Consumes the amplitude envelope and the two adaptive thresholds produced by the amplitude detector stage.
- Decides carrier presence with hysteresis and debounce, and emits burst start/end strobes for downstream frame sync/demod control.
- Measures burst length and peak amplitude, and enforces a maximum-burst timeout with holdoff.

Parameters:
- ON_CNT, 8: consecutive above-attack samples required to declare a burst (>=1).
- OFF_CNT, 16: consecutive below-release samples required to end a burst (>=1).
- LEN_W, 16: width of the burst length counter.
- MAX_LEN, 40000: burst length in cycles that forces timeout (1..2^LEN_W-1).

Ports:
- clk  in  1  system clock
- reset_b  in  1  asynchronous active-low reset
- ampl  in  20  unsigned amplitude envelope
- thresh_hi  in  20  unsigned attack threshold (amplitude detector thresh)
- thresh_lo  in  20  unsigned release threshold (amplitude detector thresh_8psk)
- carrier_det  out  1  level, high while state is ACTIVE or RELEASE
- burst_start  out  1  one-cycle pulse on entry to ACTIVE from ARM
- burst_end  out  1  one-cycle pulse when a burst ends (normal or timeout)
- burst_timeout  out  1  one-cycle pulse coincident with burst_end on timeout only
- burst_len  out  LEN_W  length of the last burst, updated with burst_end
- peak_ampl  out  20  max ampl of the last burst, updated with burst_end

Behaviour:
- Clock and reset: single clock clk. reset_b is asynchronous, active-low. All registers clear on reset, including state=IDLE. Outputs are 0 in reset. Reset mid-burst drops carrier_det immediately with no burst_end.
- Input stage: registers above_r <= (ampl > thresh_hi) and below_r <= (ampl <= thresh_lo), unsigned compares; also ampl_r <= ampl. The FSM uses only the registered values. above_r and below_r may both be 1 when thresh_lo >= thresh_hi; in that case above_r takes priority in IDLE/ARM and below_r in ACTIVE/RELEASE.
- Debounce counter cnt: width clog2(max(ON_CNT,OFF_CNT))+1.
- IDLE: if above_r, go to ARM with cnt=1 (when ON_CNT==1, go directly to ACTIVE with burst_start). Otherwise stay.
- ARM:
  - If above_r and cnt==ON_CNT-1: go to ACTIVE, pulse burst_start, len=1, peak=ampl_r.
  - Else if above_r: cnt+1.
  - Else: go to IDLE, cnt=0.
- ACTIVE:
  - len+1 and peak=max(peak,ampl_r) every cycle.
  - If below_r: go to RELEASE with cnt=1 (OFF_CNT==1: end immediately).
- RELEASE:
  - len and peak keep updating.
  - If below_r and cnt==OFF_CNT-1: go to IDLE, pulse burst_end, latch burst_len=len and peak_ampl=peak.
  - Else if below_r: cnt+1.
  - Else: go back to ACTIVE with cnt=0.
- Timeout: in ACTIVE or RELEASE, when len==MAX_LEN (checked before increment), go to HOLDOFF, pulse burst_end and burst_timeout, latch burst_len=MAX_LEN. Timeout has priority over the RELEASE end condition in the same cycle.
- HOLDOFF: carrier_det=0. Require OFF_CNT consecutive below_r, then go to IDLE with no pulse. Any non-below sample resets cnt=0.
- Latency: the first above-threshold ampl presented before edge k yields burst_start and carrier_det high after edge k+ON_CNT. End latency after the first below sample is OFF_CNT+1 edges.
- len never wraps; MAX_LEN bounds it.
- burst_len and peak_ampl hold their values until the next burst_end.

Decomposition:
- Shared package: FSM state encoding (IDLE, ARM, ACTIVE, RELEASE, HOLDOFF) and the clog2 helper function.
- Sub-module burst_debounce: a generic consecutive-event counter (inputs cond, clear, limit; output hit), instantiated once. The FSM steers its limit between ON_CNT and OFF_CNT.
- All other logic lives in the top module.

Test Plan:
- ON_CNT=8, thresh_hi=1000, thresh_lo=800. ampl=1200 starting at edge 0 -> burst_start pulse and carrier_det=1 after edge 8.
- Debounce reject: ampl=1200 for 7 cycles, then 500 -> no burst_start, state returns to IDLE, outputs stay 0.
- Hysteresis and end: burst active, ampl=900 for 100 cycles -> stays ACTIVE. Then ampl=500 for 16 cycles -> burst_end after the 17th edge; burst_len = cycles since burst_start inclusive; peak_ampl equals the max injected value (e.g., 3000 spike).
- Release abort: 10 low samples, then 1 high, then 16 low -> only one burst_end, at the end of the final 16-low run.
- Timeout with MAX_LEN=200 and ampl held at 1200 -> burst_end and burst_timeout coincident, burst_len=200, carrier_det=0. No new burst_start until 16 low samples followed by a new 8-high run.
- Async reset: assert reset_b=0 mid-ACTIVE -> carrier_det=0 immediately, all outputs 0, no burst_end. After release, the block behaves as from power-up.

Source files
------------

// File: rtl/burst_detector_pkg.sv
// Shared definitions for the burst detector: FSM state encoding, amplitude
// width and a constant-evaluable ceil(log2) helper.
package burst_detector_pkg;

    localparam int AMPL_W = 20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_ACTIVE,
        S_RELEASE,
        S_HOLDOFF
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/burst_debounce.sv
// Consecutive-event counter: hit fires on the limit-th consecutive cycle
// with cond high; any gap, a hit, or clear restarts the count from zero.
module burst_debounce #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             cond,
    input  logic             clear,
    input  logic [CNT_W-1:0] limit,
    output logic             hit
);

    logic [CNT_W-1:0] r_cnt;

    assign hit = cond && (r_cnt == (limit - CNT_W'(1)));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_cnt <= '0;
        end else if (clear || !cond || hit) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/burst_detector.sv
// Carrier burst detector: hysteresis/debounce FSM over registered threshold
// compares, with burst length/peak measurement and max-length timeout.
module burst_detector
    import burst_detector_pkg::*;
#(
    parameter int ON_CNT  = 8,
    parameter int OFF_CNT = 16,
    parameter int LEN_W   = 16,
    parameter int MAX_LEN = 40000
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic [AMPL_W-1:0] ampl,
    input  logic [AMPL_W-1:0] thresh_hi,
    input  logic [AMPL_W-1:0] thresh_lo,
    output logic              carrier_det,
    output logic              burst_start,
    output logic              burst_end,
    output logic              burst_timeout,
    output logic [LEN_W-1:0]  burst_len,
    output logic [AMPL_W-1:0] peak_ampl
);

    localparam int CNT_W = clog2((ON_CNT > OFF_CNT) ? ON_CNT : OFF_CNT) + 1;
    localparam logic [CNT_W-1:0] ON_LIM  = CNT_W'(ON_CNT);
    localparam logic [CNT_W-1:0] OFF_LIM = CNT_W'(OFF_CNT);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    state_t             r_state;
    state_t             w_next_state;
    logic               r_above;
    logic               r_below;
    logic [AMPL_W-1:0]  r_ampl;
    logic [LEN_W-1:0]   r_len;
    logic [AMPL_W-1:0]  r_peak;
    logic               r_burst_start;
    logic               r_burst_end;
    logic               r_burst_timeout;
    logic [LEN_W-1:0]   r_burst_len;
    logic [AMPL_W-1:0]  r_peak_ampl;

    logic               w_count_on;
    logic               w_cond;
    logic [CNT_W-1:0]   w_limit;
    logic               w_hit;
    logic               w_clear;
    logic               w_start;
    logic               w_end;
    logic               w_timeout;
    logic               w_in_burst;

    // IDLE/ARM count attack samples; every other state counts release samples.
    assign w_count_on = (r_state == S_IDLE) || (r_state == S_ARM);
    assign w_cond     = w_count_on ? r_above : r_below;
    assign w_limit    = w_count_on ? ON_LIM : OFF_LIM;
    assign w_in_burst = (r_state == S_ACTIVE) || (r_state == S_RELEASE);

    burst_debounce #(
        .CNT_W (CNT_W)
    ) u_debounce (
        .clk     (clk),
        .reset_b (reset_b),
        .cond    (w_cond),
        .clear   (w_clear),
        .limit   (w_limit),
        .hit     (w_hit)
    );

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_above <= 1'b0;
            r_below <= 1'b0;
            r_ampl  <= '0;
            r_state <= S_IDLE;
        end else begin
            r_above <= (ampl > thresh_hi);
            r_below <= (ampl <= thresh_lo);
            r_ampl  <= ampl;
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_start      = 1'b0;
        w_end        = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE, S_ARM: begin
                if (w_hit) begin
                    w_next_state = S_ACTIVE;
                    w_start      = 1'b1;
                end else if (r_above) begin
                    w_next_state = S_ARM;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_ACTIVE, S_RELEASE: begin
                if (r_len == LEN_MAX) begin
                    w_next_state = S_HOLDOFF;
                    w_clear      = 1'b1;
                    w_end        = 1'b1;
                    w_timeout    = 1'b1;
                end else if (w_hit) begin
                    w_next_state = S_IDLE;
                    w_end        = 1'b1;
                end else if (r_below) begin
                    w_next_state = S_RELEASE;
                end else begin
                    w_next_state = S_ACTIVE;
                end
            end
            S_HOLDOFF: begin
                if (w_hit) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_len           <= '0;
            r_peak          <= '0;
            r_burst_start   <= 1'b0;
            r_burst_end     <= 1'b0;
            r_burst_timeout <= 1'b0;
            r_burst_len     <= '0;
            r_peak_ampl     <= '0;
        end else begin
            r_burst_start   <= w_start;
            r_burst_end     <= w_end;
            r_burst_timeout <= w_timeout;
            // len is frozen on the ending cycle so it cannot wrap at MAX_LEN.
            if (w_start) begin
                r_len  <= LEN_W'(1);
                r_peak <= r_ampl;
            end else if (w_in_burst && !w_end) begin
                r_len <= r_len + LEN_W'(1);
                if (r_ampl > r_peak) begin
                    r_peak <= r_ampl;
                end
            end
            if (w_end) begin
                r_burst_len <= r_len;
                r_peak_ampl <= r_peak;
            end
        end
    end

    assign carrier_det   = w_in_burst;
    assign burst_start   = r_burst_start;
    assign burst_end     = r_burst_end;
    assign burst_timeout = r_burst_timeout;
    assign burst_len     = r_burst_len;
    assign peak_ampl     = r_peak_ampl;

endmodule

// File: tb/tb_burst_detector.sv
// Scoreboard bench for burst_detector: stimulus queues expected start/end
// events with hand-derived edge numbers; a negedge monitor checks them.
module tb_burst_detector;

    localparam int ON_CNT  = 8;
    localparam int OFF_CNT = 16;
    localparam int LEN_W   = 16;
    localparam int MAX_LEN = 200;

    typedef struct {
        bit          is_end;
        bit          timeout;
        int unsigned at_edge;
        int unsigned len;
        int unsigned peak;
    } ev_t;

    logic              clk;
    logic              reset_b;
    logic [19:0]       ampl;
    logic [19:0]       thresh_hi;
    logic [19:0]       thresh_lo;
    logic              carrier_det;
    logic              burst_start;
    logic              burst_end;
    logic              burst_timeout;
    logic [LEN_W-1:0]  burst_len;
    logic [19:0]       peak_ampl;

    int unsigned edge_cnt = 0;
    int          n_vec    = 0;
    int          n_err    = 0;
    int          n_starts = 0;
    int          n_ends   = 0;
    int unsigned k;
    ev_t         exp_q[$];
    ev_t         mon_ev;

    burst_detector #(
        .ON_CNT  (ON_CNT),
        .OFF_CNT (OFF_CNT),
        .LEN_W   (LEN_W),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk           (clk),
        .reset_b       (reset_b),
        .ampl          (ampl),
        .thresh_hi     (thresh_hi),
        .thresh_lo     (thresh_lo),
        .carrier_det   (carrier_det),
        .burst_start   (burst_start),
        .burst_end     (burst_end),
        .burst_timeout (burst_timeout),
        .burst_len     (burst_len),
        .peak_ampl     (peak_ampl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, actual, expected, edge_cnt);
        end
    endtask

    task automatic push_ev(input bit is_end, input bit timeout, input int unsigned at_edge,
                           input int unsigned len, input int unsigned peak);
        ev_t e;
        e.is_end  = is_end;
        e.timeout = timeout;
        e.at_edge = at_edge;
        e.len     = len;
        e.peak    = peak;
        exp_q.push_back(e);
    endtask

    // Each call presents one value per cycle; caller must be at a negedge.
    task automatic drive(input int unsigned v, input int n);
        for (int i = 0; i < n; i++) begin
            ampl = 20'(v);
            @(negedge clk);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_carrier"}, carrier_det, 0);
        check({tag, "_start"}, burst_start, 0);
        check({tag, "_end"}, burst_end, 0);
        check({tag, "_timeout"}, burst_timeout, 0);
        check({tag, "_len"}, burst_len, 0);
        check({tag, "_peak"}, peak_ampl, 0);
    endtask

    always @(negedge clk) begin
        if (reset_b && (burst_start || burst_end)) begin
            if (burst_start) n_starts++;
            if (burst_end) n_ends++;
            if (exp_q.size() == 0) begin
                check("unexpected_event", {burst_end, burst_start}, 0);
            end else begin
                mon_ev = exp_q.pop_front();
                check("event_kind_end", burst_end, mon_ev.is_end);
                check("event_edge", edge_cnt, mon_ev.at_edge);
                check("event_timeout", burst_timeout, mon_ev.timeout);
                check("event_carrier", carrier_det, !mon_ev.is_end);
                if (mon_ev.is_end) begin
                    check("burst_len", burst_len, mon_ev.len);
                    check("peak_ampl", peak_ampl, mon_ev.peak);
                end
            end
        end
    end

    initial begin
        reset_b   = 1'b0;
        ampl      = '0;
        thresh_hi = 20'd1000;
        thresh_lo = 20'd800;
        repeat (3) @(negedge clk);
        check_all_zero("por");
        reset_b = 1'b1;
        drive(500, 4);

        // Start latency, hysteresis hold at 900, spike peak, normal end.
        k = edge_cnt + 1;
        push_ev(0, 0, k + 8, 0, 0);
        push_ev(1, 0, k + 127, 119, 3000);
        drive(1200, 10);
        drive(3000, 1);
        drive(900, 100);
        check("hyst_carrier", carrier_det, 1);
        drive(500, 16);
        drive(500, 4);
        check("post_end_carrier", carrier_det, 0);

        // Debounce reject (7 highs) and ampl == thresh_hi is not an attack.
        drive(1200, 7);
        drive(500, 20);
        drive(1000, 20);
        check("reject_carrier", carrier_det, 0);

        // Release abort; ampl == thresh_lo counts as a release sample.
        k = edge_cnt + 1;
        push_ev(0, 0, k + 8, 0, 0);
        push_ev(1, 0, k + 37, 29, 1500);
        drive(1200, 10);
        drive(800, 10);
        check("release_carrier", carrier_det, 1);
        drive(1500, 1);
        drive(800, 16);
        drive(500, 6);

        // Timeout, holdoff interrupted once, then a fresh burst.
        k = edge_cnt + 1;
        push_ev(0, 0, k + 8, 0, 0);
        push_ev(1, 1, k + 208, 200, 1200);
        push_ev(0, 0, k + 270, 0, 0);
        push_ev(1, 0, k + 288, 18, 1200);
        drive(1200, 230);
        check("timeout_carrier", carrier_det, 0);
        drive(500, 15);
        check("holdoff_carrier", carrier_det, 0);
        drive(1200, 1);
        drive(500, 16);
        drive(1200, 10);
        drive(500, 16);
        drive(500, 4);

        // Async reset mid-ACTIVE: outputs clear at once, no burst_end.
        k = edge_cnt + 1;
        push_ev(0, 0, k + 8, 0, 0);
        drive(1200, 12);
        check("pre_reset_carrier", carrier_det, 1);
        #2 reset_b = 1'b0;
        #1 check_all_zero("async_rst");
        ampl = 20'd500;
        repeat (3) @(negedge clk);
        reset_b = 1'b1;

        k = edge_cnt + 1;
        push_ev(0, 0, k + 8, 0, 0);
        push_ev(1, 0, k + 25, 17, 1001);
        drive(1001, 9);
        drive(500, 16);
        drive(500, 4);

        check("events_pending", exp_q.size(), 0);
        check("start_count", n_starts, 6);
        check("end_count", n_ends, 5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
